// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes, ownership state, lane masks.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic {
    NONE = 1'b0,
    P1   = 1'b1
  } owner_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = 4'b0011 << off;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for one access: store replication, write mask, load extraction/extension, alignment error.
// Purely combinational; applied to whichever request won arbitration.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  always_comb begin
    err   = (size == SZ_R) || ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    wmask = lane_mask(size, off);
    case (off)
      2'd0:    rd_b = rdata_raw[7:0];
      2'd1:    rd_b = rdata_raw[15:8];
      2'd2:    rd_b = rdata_raw[23:16];
      default: rd_b = rdata_raw[31:24];
    endcase
    rd_h = off[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (size)
      SZ_B: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{rd_b[7] & ~uns}}, rd_b};
      end
      SZ_H: begin
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{rd_h[15] & ~uns}}, rd_h};
      end
      default: begin
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single byte-lane data memory; grant is combinational,
// the formatted load/store response is registered and returned one cycle after grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter bit RR_EN   = 1'b1,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_uns,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_uns,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_rdata
);

  owner_e      owner_q, owner_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic        p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  logic        any_gnt, req_we, req_uns, fmt_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rdata_ext, rsp_rdata;
  logic [3:0]  wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= NONE;
      rr_ptr_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rvalid_q <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      p0_rvalid_q <= p0_rvalid_d;
      p0_err_q    <= p0_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rvalid_q <= p1_rvalid_d;
      p1_err_q    <= p1_err_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  // Grant: a locked owner shuts port 0 out, including the cycle the lock drops.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (LOCK_EN && (owner_q == P1)) begin
        p1_gnt = p1_req;
      end else if (p0_req && p1_req) begin
        if (RR_EN && rr_ptr_q) p1_gnt = 1'b1;
        else                   p0_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  always_comb begin
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (p0_gnt) rr_ptr_d = 1'b1;
    if (p1_gnt) rr_ptr_d = 1'b0;
    if (LOCK_EN && p1_gnt && p1_lock) owner_d = P1;
    else if (!p1_lock)                owner_d = NONE;
  end

  always_comb begin
    any_gnt   = p0_gnt | p1_gnt;
    req_we    = p1_gnt ? p1_we    : p0_we;
    req_size  = p1_gnt ? p1_size  : p0_size;
    req_uns   = p1_gnt ? p1_uns   : p0_uns;
    req_addr  = p1_gnt ? p1_addr  : p0_addr;
    req_wdata = p1_gnt ? p1_wdata : p0_wdata;
  end

  dmem_lane_fmt u_fmt (
    .size      (req_size),
    .uns       (req_uns),
    .off       (req_addr[1:0]),
    .wdata     (req_wdata),
    .rdata_raw (mem_rdata),
    .wmask     (wmask),
    .wdata_rep (mem_wdata),
    .rdata_ext (rdata_ext),
    .err       (fmt_err)
  );

  always_comb begin
    mem_addr    = {req_addr[31:2], 2'b00};
    mem_wren    = (any_gnt && req_we && !fmt_err) ? wmask : 4'b0000;
    rsp_rdata   = (req_we || fmt_err) ? 32'h0 : rdata_ext;
    p0_rvalid_d = p0_gnt;
    p0_rdata_d  = p0_gnt ? rsp_rdata : p0_rdata_q;
    p0_err_d    = p0_gnt ? fmt_err   : p0_err_q;
    p1_rvalid_d = p1_gnt;
    p1_rdata_d  = p1_gnt ? rsp_rdata : p1_rdata_q;
    p1_err_d    = p1_gnt ? fmt_err   : p1_err_q;
  end

  // Responses read as reset values while rst is high, so an in-flight response is dropped.
  always_comb begin
    p0_rvalid = p0_rvalid_q & ~rst;
    p0_rdata  = rst ? 32'h0 : p0_rdata_q;
    p0_err    = p0_err_q & ~rst;
    p1_rvalid = p1_rvalid_q & ~rst;
    p1_rdata  = rst ? 32'h0 : p1_rdata_q;
    p1_err    = p1_err_q & ~rst;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked against a byte-array memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, p1_lock;
  logic        p0_req, p0_we, p0_uns, p1_req, p1_we, p1_uns;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wren;
  logic        f0_gnt, f0_rvalid, f0_err, f1_gnt, f1_rvalid, f1_err;
  logic [31:0] f0_rdata, f1_rdata, fmem_addr, fmem_wdata, fmem_rdata;
  logic [3:0]  fmem_wren;

  logic [31:0] ram  [0:63] = '{default: 32'h0};
  logic [31:0] fram [0:63] = '{default: 32'h0};
  assign mem_rdata  = ram[mem_addr[7:2]];
  assign fmem_rdata = fram[fmem_addr[7:2]];
  always @(posedge clk)
    for (int i = 0; i < 4; i++) begin
      if (mem_wren[i])  ram[mem_addr[7:2]][i*8 +: 8]   <= mem_wdata[i*8 +: 8];
      if (fmem_wren[i]) fram[fmem_addr[7:2]][i*8 +: 8] <= fmem_wdata[i*8 +: 8];
    end

  dmem_arbiter #(.RR_EN(1'b1), .LOCK_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.RR_EN(1'b0), .LOCK_EN(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(f0_gnt), .p0_rvalid(f0_rvalid), .p0_rdata(f0_rdata), .p0_err(f0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(f1_gnt), .p1_rvalid(f1_rvalid),
    .p1_rdata(f1_rdata), .p1_err(f1_err),
    .mem_addr(fmem_addr), .mem_wdata(fmem_wdata), .mem_wren(fmem_wren), .mem_rdata(fmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_mem [0:255];
  bit          m_own, m_ptr, f_own;
  bit          m_rv [2];
  bit          m_er [2];
  logic [31:0] m_rd [2];
  int          last_w;
  logic        l_g0, l_g1, l_f0, l_rv1;
  logic [3:0]  l_wren;
  logic [31:0] l_wdata;
  bit          pend [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Which port should win this cycle (-1 = none), from the arbitration rules.
  function automatic int pick(bit rr, bit own, bit ptr, logic r0, logic r1, logic rs);
    if (rs)       return -1;
    if (own)      return r1 ? 1 : -1;
    if (r0 && r1) return (rr && ptr) ? 1 : 0;
    if (r0)       return 0;
    if (r1)       return 1;
    return -1;
  endfunction

  task automatic cycle();
    int          w, wf, n, off;
    bit          e;
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wd, v, ew;
    logic [3:0]  em;
    #1;
    w  = pick(1'b1, m_own, m_ptr, p0_req, p1_req, rst);
    wf = pick(1'b0, f_own, 1'b0, p0_req, p1_req, rst);
    chk("gnt0", 32'(p0_gnt), 32'(w == 0));
    chk("gnt1", 32'(p1_gnt), 32'(w == 1));
    chk("fp_gnt0", 32'(f0_gnt), 32'(wf == 0));
    chk("fp_gnt1", 32'(f1_gnt), 32'(wf == 1));
    chk("rvalid0", 32'(p0_rvalid), rst ? 32'h0 : 32'(m_rv[0]));
    chk("rvalid1", 32'(p1_rvalid), rst ? 32'h0 : 32'(m_rv[1]));
    chk("rdata0", p0_rdata, rst ? 32'h0 : m_rd[0]);
    chk("rdata1", p1_rdata, rst ? 32'h0 : m_rd[1]);
    chk("err0", 32'(p0_err), rst ? 32'h0 : 32'(m_er[0]));
    chk("err1", 32'(p1_err), rst ? 32'h0 : 32'(m_er[1]));
    l_g0 = p0_gnt; l_g1 = p1_gnt; l_f0 = f0_gnt; l_rv1 = p1_rvalid;
    l_wren = mem_wren; l_wdata = mem_wdata;
    em = 4'h0;
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (w >= 0) begin
      addr = (w == 1) ? p1_addr  : p0_addr;
      wd   = (w == 1) ? p1_wdata : p0_wdata;
      sz   = (w == 1) ? p1_size  : p0_size;
      we   = (w == 1) ? p1_we    : p0_we;
      uns  = (w == 1) ? p1_uns   : p0_uns;
      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off  = int'(addr[1:0]);
      e    = (sz == 2'd3) || ((off % n) != 0);
      v    = 32'h0;
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      if (!e && we) begin
        for (int k = 0; k < n; k++) begin
          em[off + k] = 1'b1;
          m_mem[int'(addr[7:0]) + k] = wd[8*k +: 8];
        end
        for (int i = 0; i < 4; i++) ew[8*i +: 8] = wd[8*(i % n) +: 8];
        chk("mem_wdata", mem_wdata, ew);
      end else if (!e) begin
        for (int k = 0; k < n; k++) v[8*k +: 8] = m_mem[int'(addr[7:0]) + k];
        if (!uns && n == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (!uns && n == 2 && v[15]) v[31:16] = 16'hFFFF;
      end
      m_rv[w] = 1'b1;
      m_rd[w] = v;
      m_er[w] = e;
    end
    chk("mem_wren", 32'(mem_wren), 32'(em));
    if (rst) begin
      m_own = 1'b0; m_ptr = 1'b0; f_own = 1'b0;
      for (int p = 0; p < 2; p++) begin m_rv[p] = 1'b0; m_rd[p] = 32'h0; m_er[p] = 1'b0; end
    end else begin
      if (w >= 0) m_ptr = (w == 0);
      if (w == 1 && p1_lock)  m_own = 1'b1;
      else if (!p1_lock)      m_own = 1'b0;
      if (wf == 1 && p1_lock) f_own = 1'b1;
      else if (!p1_lock)      f_own = 1'b0;
    end
    last_w = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_p(input int p, input logic req, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_size = sz; p0_uns = uns; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = req; p1_we = we; p1_size = sz; p1_uns = uns; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic gen(input int p);
    logic [1:0]  sz;
    logic [31:0] a;
    sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a  = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz >= 2'd2) a[1:0] = 2'b00;
    end
    set_p(p, 1'b1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h0;
    for (int p = 0; p < 2; p++) begin m_rv[p] = 1'b0; m_rd[p] = 32'h0; m_er[p] = 1'b0; pend[p] = 1'b0; end
    m_own = 1'b0; m_ptr = 1'b0; f_own = 1'b0;
    rst = 1'b1; p1_lock = 1'b0;
    set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678);
    set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_wren", 32'(l_wren), 32'h0);
    rst = 1'b0;
    set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    cycle();

    set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF); cycle();
    chk("st_w_wren", 32'(l_wren), 32'hF);
    set_p(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0); cycle();
    chk("ldb_signed", p0_rdata, 32'hFFFFFFDE);
    set_p(0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0); cycle();
    chk("ldb_unsigned", p0_rdata, 32'h000000DE);
    set_p(0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000A5A5); cycle();
    chk("st_h_wren", 32'(l_wren), 32'hC);
    chk("st_h_wdata", l_wdata, 32'hA5A5A5A5);
    set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0); cycle();
    chk("ldw_merge", p0_rdata, 32'hA5A5BEEF);
    set_p(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h101, 32'h11111111); cycle();
    chk("mis_gnt", 32'(l_g0), 32'h1);
    chk("mis_wren", 32'(l_wren), 32'h0);
    chk("mis_rvalid", 32'(p0_rvalid), 32'h1);
    chk("mis_err", 32'(p0_err), 32'h1);
    chk("mis_rdata", p0_rdata, 32'h0);
    set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0); cycle();
    chk("ldw_unchanged", p0_rdata, 32'hA5A5BEEF);

    rst = 1'b1; set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0); cycle();
    rst = 1'b0;
    set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    set_p(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_alternate", 32'(l_g0), 32'(i % 2 == 0));
      chk("fp_p0_wins", 32'(l_f0), 32'h1);
    end

    set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0); cycle();
    p1_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_p(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h110 + 32'(4 * i), 32'(i)); cycle();
      chk("lock_p1_gnt", 32'(l_g1), 32'h1);
      chk("lock_p0_stall", 32'(l_g0), 32'h0);
    end
    p1_lock = 1'b0; set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0); cycle();
    chk("unlock_p0_wait", 32'(l_g0), 32'h0);
    cycle();
    chk("unlock_p0_gnt", 32'(l_g0), 32'h1);

    set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    p1_lock = 1'b1; set_p(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h110, 32'h0); cycle();
    rst = 1'b1; set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    set_p(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0); cycle();
    chk("rst_drop_rvalid", 32'(l_rv1), 32'h0);
    chk("rst_no_gnt", 32'(l_g0), 32'h0);
    rst = 1'b0; p1_lock = 1'b0; cycle();
    chk("post_rst_gnt", 32'(l_g0), 32'h1);

    set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) p1_lock = ~p1_lock;
      for (int p = 0; p < 2; p++)
        if (!pend[p]) begin
          if ($urandom_range(0, 2) != 0) gen(p);
          else set_p(p, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        end
      cycle();
      pend[0] = p0_req && (last_w != 0);
      pend[1] = p1_req && (last_w != 1);
    end
    rst = 1'b0; p1_lock = 1'b0;
    set_p(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    set_p(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
